// File: rtl/fft_iter_pkg.sv
// Shared constants and helpers for the iterative radix-4 FFT.
// Used by the address generator and the digit-reversal unloader.
package fft_iter_pkg;

    localparam int RADIX      = 4;
    localparam int FFT_STAGES = 3;
    localparam int N          = RADIX ** FFT_STAGES;
    localparam int FFT_AWL    = 2 * FFT_STAGES;

    // Insert one zero radix-4 digit (two bits) at bit position pos.
    function automatic logic [31:0] digit_insert(
        input logic [31:0] v,
        input int          pos
    );
        logic [31:0] lo_mask;
        lo_mask = (32'd1 << pos) - 32'd1;
        return ((v & ~lo_mask) << 2) | (v & lo_mask);
    endfunction

endpackage

// File: rtl/fft_r4_addr_calc.sv
// Combinational radix-4 DIF leg and twiddle addresses for
// butterfly b of stage s.
module fft_r4_addr_calc
    import fft_iter_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int ButtWL = 4,
    parameter int LayWL  = 2,
    parameter int AddrWL = 6
) (
    input  logic [ButtWL-1:0]         b_i,
    input  logic [LayWL-1:0]          s_i,
    output logic [AddrWL-1:0]         base_o,
    output logic [3:0][AddrWL-1:0]    rd_o,
    output logic [2:0][AddrWL-1:0]    tw_o
);

    always_comb begin
        int          sh;
        logic [31:0] b32;
        logic [31:0] span;
        logic [31:0] base32;
        logic [31:0] k;
        sh     = 2 * (STAGES - 1 - int'(s_i));
        b32    = 32'(b_i);
        span   = 32'd1 << sh;
        base32 = digit_insert(b32, sh);
        // Twiddle exponent: position within the group, scaled by stage.
        k      = (b32 & (span - 32'd1)) << (2 * int'(s_i));
        base_o = AddrWL'(base32);
        for (int m = 0; m < 4; m++) begin
            rd_o[m] = AddrWL'(base32 + 32'(m) * span);
        end
        tw_o[0] = AddrWL'(k);
        tw_o[1] = AddrWL'(k << 1);
        tw_o[2] = AddrWL'(k * 32'd3);
    end

endmodule

// File: rtl/addr_gen_fft_iter_but4.sv
// Iterative radix-4 FFT address generator: butterfly/stage counters,
// write-address latch and BUSY/DONE status.
module addr_gen_fft_iter_but4
    import fft_iter_pkg::*;
#(
    parameter int STAGES      = FFT_STAGES,
    parameter int BUTTERFLYES = 16,
    parameter int ButtWL      = 4,
    parameter int LayWL       = 2,
    parameter int AddrWL      = FFT_AWL
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              START,
    input  logic              BUT_STROB,
    input  logic              ADDR_EN,
    output logic [AddrWL-1:0] RD_ADDR0,
    output logic [AddrWL-1:0] RD_ADDR1,
    output logic [AddrWL-1:0] RD_ADDR2,
    output logic [AddrWL-1:0] RD_ADDR3,
    output logic [AddrWL-1:0] WR_ADDR0,
    output logic [AddrWL-1:0] WR_ADDR1,
    output logic [AddrWL-1:0] WR_ADDR2,
    output logic [AddrWL-1:0] WR_ADDR3,
    output logic [AddrWL-1:0] TW_ADDR1,
    output logic [AddrWL-1:0] TW_ADDR2,
    output logic [AddrWL-1:0] TW_ADDR3,
    output logic [LayWL-1:0]  STAGE,
    output logic              BUSY,
    output logic              DONE
);

    logic [ButtWL-1:0]      butt_q, butt_d;
    logic [LayWL-1:0]       stage_q, stage_d;
    logic [3:0][AddrWL-1:0] wr_q, wr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [AddrWL-1:0]      base;
    logic [3:0][AddrWL-1:0] rd;
    logic [2:0][AddrWL-1:0] tw;

    fft_r4_addr_calc #(
        .STAGES (STAGES),
        .ButtWL (ButtWL),
        .LayWL  (LayWL),
        .AddrWL (AddrWL)
    ) u_calc (
        .b_i    (butt_q),
        .s_i    (stage_q),
        .base_o (base),
        .rd_o   (rd),
        .tw_o   (tw)
    );

    always_comb begin
        butt_d  = butt_q;
        stage_d = stage_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (EN) begin
            if (START) begin
                butt_d  = '0;
                stage_d = '0;
                busy_d  = 1'b1;
            end else begin
                // Latch the pre-increment addresses.
                if (BUT_STROB) wr_d = rd;
                if (ADDR_EN && busy_q) begin
                    if (butt_q != ButtWL'(BUTTERFLYES - 1)) begin
                        butt_d = butt_q + 1'b1;
                    end else begin
                        butt_d = '0;
                        if (stage_q == LayWL'(STAGES - 1)) begin
                            stage_d = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            stage_d = stage_q + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            butt_q  <= '0;
            stage_q <= '0;
            wr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            butt_q  <= butt_d;
            stage_q <= stage_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign RD_ADDR0 = rd[0];
    assign RD_ADDR1 = rd[1];
    assign RD_ADDR2 = rd[2];
    assign RD_ADDR3 = rd[3];
    assign WR_ADDR0 = wr_q[0];
    assign WR_ADDR1 = wr_q[1];
    assign WR_ADDR2 = wr_q[2];
    assign WR_ADDR3 = wr_q[3];
    assign TW_ADDR1 = tw[0];
    assign TW_ADDR2 = tw[1];
    assign TW_ADDR3 = tw[2];
    assign STAGE    = stage_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

    logic unused_base;
    assign unused_base = ^base;

endmodule

// File: tb/tb_addr_gen_fft_iter_but4.sv
// Scoreboard bench for the radix-4 address generator (STAGES=3, N=64).
// Expected outputs are queued per cycle and checked after each edge.
module tb_addr_gen_fft_iter_but4;

    typedef struct packed {
        logic [3:0][5:0] rd;
        logic [3:0][5:0] wr;
        logic [2:0][5:0] tw;
        logic [1:0]      stage;
        logic            busy;
        logic            done;
    } obs_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0;
    logic       START = 1'b0;
    logic       BUT_STROB = 1'b0;
    logic       ADDR_EN = 1'b0;
    logic [5:0] rd0, rd1, rd2, rd3;
    logic [5:0] wr0, wr1, wr2, wr3;
    logic [5:0] tw1, tw2, tw3;
    logic [1:0] stage;
    logic       busy, done;

    int   n_checks = 0;
    int   n_fail = 0;
    obs_t q[$];

    int   mb, ms;
    bit   mbusy, mdone;
    int   mwr[4];

    always #5 CLK = ~CLK;

    addr_gen_fft_iter_but4 dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .START     (START),
        .BUT_STROB (BUT_STROB),
        .ADDR_EN   (ADDR_EN),
        .RD_ADDR0  (rd0),
        .RD_ADDR1  (rd1),
        .RD_ADDR2  (rd2),
        .RD_ADDR3  (rd3),
        .WR_ADDR0  (wr0),
        .WR_ADDR1  (wr1),
        .WR_ADDR2  (wr2),
        .WR_ADDR3  (wr3),
        .TW_ADDR1  (tw1),
        .TW_ADDR2  (tw2),
        .TW_ADDR3  (tw3),
        .STAGE     (stage),
        .BUSY      (busy),
        .DONE      (done)
    );

    // Group size 4^(2-s); legs of a group are span apart.
    function automatic int exp_rd(input int b, input int s, input int m);
        int span;
        span = 64 >> (2 * (s + 1));
        return ((b / span) * span * 4 + (b % span) + m * span) % 64;
    endfunction

    function automatic int exp_tw(input int b, input int s, input int t);
        int span;
        span = 64 >> (2 * (s + 1));
        return ((b % span) * (4 ** s) * t) % 64;
    endfunction

    function automatic obs_t model_exp();
        obs_t e;
        for (int m = 0; m < 4; m++) begin
            e.rd[m] = 6'(exp_rd(mb, ms, m));
            e.wr[m] = 6'(mwr[m]);
        end
        for (int t = 1; t <= 3; t++) e.tw[t-1] = 6'(exp_tw(mb, ms, t));
        e.stage = 2'(ms);
        e.busy  = mbusy;
        e.done  = mdone;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.rd    = {rd3, rd2, rd1, rd0};
        o.wr    = {wr3, wr2, wr1, wr0};
        o.tw    = {tw3, tw2, tw1};
        o.stage = stage;
        o.busy  = busy;
        o.done  = done;
        return o;
    endfunction

    task automatic model_reset();
        mb = 0; ms = 0; mbusy = 0; mdone = 0;
        for (int m = 0; m < 4; m++) mwr[m] = 0;
    endtask

    task automatic model_step(input bit en, input bit st, input bit bs, input bit ae);
        bit dn;
        dn = 0;
        if (en) begin
            if (st) begin
                mb = 0; ms = 0; mbusy = 1;
            end else begin
                if (bs) for (int m = 0; m < 4; m++) mwr[m] = exp_rd(mb, ms, m);
                if (ae && mbusy) begin
                    if (mb < 15) mb++;
                    else begin
                        mb = 0;
                        if (ms == 2) begin
                            ms = 0; mbusy = 0; dn = 1;
                        end else ms++;
                    end
                end
            end
        end
        mdone = dn;
    endtask

    task automatic drive(input bit en, input bit st, input bit bs, input bit ae);
        EN = en; START = st; BUT_STROB = bs; ADDR_EN = ae;
        model_step(en, st, bs, ae);
        @(posedge CLK);
        #1;
        q.push_back(model_exp());
        EN = 0; START = 0; BUT_STROB = 0; ADDR_EN = 0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        RST = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1;
        drive(0, 0, 0, 0);
        e = q.pop_front(); o = sample(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_state got %p want %p", o, e);
        end
        n_checks++;
        if ({rd0, rd1, rd2, rd3} !== {6'd0, 6'd16, 6'd32, 6'd48}) begin
            n_fail++;
            $display("FAIL reset_rd got %0d %0d %0d %0d want 0 16 32 48", rd0, rd1, rd2, rd3);
        end
    endtask

    task automatic test_stage_walk();
        obs_t e, o;
        drive(1, 1, 0, 0);
        e = q.pop_front(); o = sample(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL walk_start got %p want %p", o, e);
        end
        for (int i = 0; i < 37; i++) begin
            drive(1, 0, 0, 1);
            e = q.pop_front(); o = sample(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL walk_step%0d got %p want %p", i, o, e);
            end
            if (i == 4) begin
                n_checks++;
                if ({rd0, rd1, rd2, rd3, tw1, tw2, tw3, stage} !==
                    {6'd5, 6'd21, 6'd37, 6'd53, 6'd5, 6'd10, 6'd15, 2'd0}) begin
                    n_fail++;
                    $display("FAIL walk_s0b5 got rd %0d %0d tw %0d %0d", rd0, rd3, tw1, tw3);
                end
            end
            if (i == 20) begin
                n_checks++;
                if ({rd0, rd1, rd2, rd3, tw1, tw2, tw3, stage} !==
                    {6'd17, 6'd21, 6'd25, 6'd29, 6'd4, 6'd8, 6'd12, 2'd1}) begin
                    n_fail++;
                    $display("FAIL walk_s1b5 got rd %0d %0d tw %0d %0d", rd0, rd3, tw1, tw3);
                end
            end
            if (i == 36) begin
                n_checks++;
                if ({rd0, rd1, rd2, rd3, tw1, tw2, tw3, stage} !==
                    {6'd20, 6'd21, 6'd22, 6'd23, 6'd0, 6'd0, 6'd0, 2'd2}) begin
                    n_fail++;
                    $display("FAIL walk_s2b5 got rd %0d %0d tw %0d %0d", rd0, rd3, tw1, tw3);
                end
            end
        end
    endtask

    task automatic test_strobe_advance();
        obs_t e, o;
        drive(1, 1, 0, 0);
        void'(q.pop_front());
        for (int i = 0; i < 21; i++) begin
            drive(1, 0, 0, 1);
            e = q.pop_front(); o = sample(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sa_step%0d got %p want %p", i, o, e);
            end
        end
        drive(1, 0, 1, 1);
        e = q.pop_front(); o = sample(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL sa_both got %p want %p", o, e);
        end
        n_checks++;
        if ({wr0, wr1, wr2, wr3, rd0, rd1, rd2, rd3} !==
            {6'd17, 6'd21, 6'd25, 6'd29, 6'd18, 6'd22, 6'd26, 6'd30}) begin
            n_fail++;
            $display("FAIL sa_wr got wr %0d %0d rd %0d %0d want wr 17 29 rd 18 30",
                     wr0, wr3, rd0, rd3);
        end
        // START outranks strobe and advance in the same cycle.
        drive(1, 1, 1, 1);
        e = q.pop_front(); o = sample(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL sa_start_prio got %p want %p", o, e);
        end
    endtask

    task automatic test_full_run();
        obs_t e, o;
        drive(1, 1, 0, 0);
        void'(q.pop_front());
        for (int i = 0; i < 48; i++) begin
            drive(1, 0, (i % 3) == 0, 1);
            e = q.pop_front(); o = sample(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL run_step%0d got %p want %p", i, o, e);
            end
        end
        n_checks++;
        if ({done, busy, stage} !== {1'b1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL run_done got done=%0b busy=%0b stage=%0d want 1 0 0", done, busy, stage);
        end
        // DONE clears even with EN low; idle advances are ignored.
        drive(0, 0, 0, 1);
        e = q.pop_front(); o = sample(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL run_done_clear got %p want %p", o, e);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1);
            e = q.pop_front(); o = sample(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL run_idle%0d got %p want %p", i, o, e);
            end
        end
    endtask

    task automatic test_en_restart();
        obs_t e, o;
        drive(1, 1, 0, 0);
        void'(q.pop_front());
        for (int i = 0; i < 82; i++) begin
            drive(i % 2 == 0, 0, 1, 1);
            e = q.pop_front(); o = sample(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL en_step%0d got %p want %p", i, o, e);
            end
        end
        n_checks++;
        if ({stage, rd0} !== {2'd2, 6'd36}) begin
            n_fail++;
            $display("FAIL en_s2b9 got stage=%0d rd0=%0d want 2 36", stage, rd0);
        end
        drive(1, 1, 0, 0);
        e = q.pop_front(); o = sample(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL en_restart got %p want %p", o, e);
        end
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 1, 1);
            void'(q.pop_front());
        end
        #2;
        RST = 0;
        #1;
        model_reset();
        o = sample(); e = model_exp(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL async_reset got %p want %p", o, e);
        end
        @(posedge CLK);
        #1;
        RST = 1;
        drive(1, 0, 0, 1);
        e = q.pop_front(); o = sample(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL post_reset got %p want %p", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_stage_walk();
        test_strobe_advance();
        test_full_run();
        test_en_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
